mealy_pattern_detect: RTL
=========================

Name: mealy_pattern_detect

Overview:
Parametrised Mealy serial pattern detector, the successor to the fixed '101' detector. It compares an N-bit serial stream on x against a pattern that is set by parameter at reset and can be reloaded at run time. It supports overlapping and non-overlapping match modes, a sample enable, and a saturating match counter. It sits in the FSM block library and is driven by the same task-based serial stimulus benches.

Parameters:
N, 3, pattern length in bits; legal range 2..16.
PATTERN, 3'b101, reset value of the pattern, N bits wide; PATTERN[N-1] is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = bits of a completed match are not reused.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
x  input  1  serial data bit; sampled only when en=1.
en  input  1  sample enable; when 0, x is ignored and state holds.
pat_load  input  1  load pat_in as the new pattern on this rising edge.
pat_in  input  N  new pattern, same bit order as PATTERN.
cnt_clr  input  1  synchronous clear of match_cnt.
z  output  1  Mealy match output; combinational from x, en and internal state.
match_cnt  output  CNT_W  saturating count of asserted z cycles.
cur_state  output  clog2(N)  number of valid history bits, 0..N-1; for monitoring.

Behaviour:
- Reset (rst=0, asynchronous): pattern register <= PATTERN, history cleared, cur_state=0, match_cnt=0. z is forced to 0 while rst=0.
- Internal state:
  - hist: last N-1 accepted bits, newest in bit 0.
  - cur_state: valid-bit fill count, saturating at N-1.
- z = en & ~pat_load & (cur_state==N-1) & ({hist, x} == pattern).
  - z is combinational; zero-cycle latency from x.
  - z must be sampled before the rising edge that consumes the bit.
- On a rising edge with en=1 and pat_load=0:
  - hist <= {hist[N-3:0], x}.
  - If z=1 and OVERLAP=0: cur_state <= 0, so the matched bits are discarded.
  - Otherwise: cur_state <= min(cur_state+1, N-1).
- en=0: hist, cur_state and match_cnt hold. z=0.
- pat_load=1 takes priority over en:
  - pattern <= pat_in; hist and cur_state cleared.
  - The x sample in that cycle is discarded; z=0 in that cycle.
  - Matching restarts from the next accepted bit. A full N fresh bits are needed before the next match.
- match_cnt:
  - Increments by 1 on each edge where z=1.
  - Saturates at 2^CNT_W-1; it does not wrap.
- cnt_clr=1: match_cnt <= 0 on the edge. cnt_clr wins over a simultaneous increment. cnt_clr does not affect hist or the pattern.
- Reset mid-sequence: all partial history is lost, and the pattern returns to PATTERN (not the last loaded value).
- Mealy semantics: a match is flagged on the same cycle the final bit is present. There is no extra pipeline cycle.

Test Plan:
- N=3, PATTERN=101, OVERLAP=1, en=1, x=1,0,1,0,1 on consecutive edges -> z=1 during bits 3 and 5 only; match_cnt=2; cur_state sequence 0,1,2,2,2.
- OVERLAP=0, same stream 1,0,1,0,1 -> z=1 during bit 3 only; cur_state=0 after bit 3; match_cnt=1. Then extend with x=0,1 -> z=1 during bit 7; match_cnt=2.
- en gaps: x=1 (en=1), x=0 (en=0), x=0 (en=1), x=1 (en=1) -> z=1 on the last bit only; the en=0 sample has no effect.
- Runtime load: apply pat_load=1 with pat_in=110 while cur_state=2 -> z=0 that cycle, cur_state=0. Then x=1,1,0 -> z=1 on the third bit. Then x=1,0,1 -> no z.
- Reset mid-operation: after a load of 110, feed x=1,1, then pulse rst=0 for 5 ns -> cur_state=0, match_cnt=0, pattern back to 101. Then x=0 -> z=0.
- Saturation and clear: CNT_W=2, OVERLAP=1, stream 1010101010 -> match_cnt sticks at 3. cnt_clr=1 on the same edge as a match -> match_cnt=0.

Source files
------------

// File: rtl/mealy_pattern_detect_if.sv
// Serial-detector bus: groups the data, control and monitor signals of
// mealy_pattern_detect into one bundle.
//   master : drives x, en, pat_load, pat_in, cnt_clr; observes z, match_cnt, cur_state
//   slave  : the detector side (inputs and outputs reversed)
interface mealy_pattern_detect_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned SW = $clog2(N);

    logic             x;
    logic             en;
    logic             pat_load;
    logic [N-1:0]     pat_in;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic [SW-1:0]    cur_state;

    modport master (
        output x, en, pat_load, pat_in, cnt_clr,
        input  z, match_cnt, cur_state
    );

    modport slave (
        input  x, en, pat_load, pat_in, cnt_clr,
        output z, match_cnt, cur_state
    );
endinterface

// File: rtl/mealy_pattern_detect.sv
// Parametrised Mealy serial pattern detector.
// Compares the last N accepted bits (N-1 of history plus the live x) against
// a run-time reloadable pattern; z is combinational, asserted in the same
// cycle the final bit is present.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - slave side of mealy_pattern_detect_if:
//          x, en, pat_load, pat_in, cnt_clr in; z, match_cnt, cur_state out
module mealy_pattern_detect #(
    parameter int unsigned    N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b101,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    mealy_pattern_detect_if.slave bus
);
    localparam int unsigned     SW      = $clog2(N);
    localparam logic [SW-1:0]   FULL    = SW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     pat_q,  pat_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [SW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [N-1:0]     window;
    logic             z;

    // Live window: history with the current bit appended as the newest.
    // Gating with rst keeps z low for the whole reset assertion.
    always_comb begin
        window = {hist_q, bus.x};
        z      = rst & bus.en & ~bus.pat_load & (fill_q == FULL) & (window == pat_q);
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        // A load restarts matching; the x sampled alongside it is dropped.
        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            // Taking the low N-1 bits of the window also covers N=2,
            // where the history is a single bit.
            hist_d = window[N-2:0];
            if (z && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (z && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.z         = z;
    assign bus.match_cnt = cnt_q;
    assign bus.cur_state = fill_q;
endmodule
